// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master.
// State encoding and frame-width default used by spi_master and its bench.
package spi_pkg;

  localparam int SPI_WIDTH = 13;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    SHIFT,
    LATCH
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer: tick marks the last clk cycle of every HALF_DIV-cycle phase.
// Latency: first tick HALF_DIV cycles after clr drops; no backpressure, clr restarts the count.
module spi_clk_div #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // With HALF_DIV=1 the counter sits at zero and ticks every cycle.
  assign tick = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, frames bracketed by load pulses; done HALF_DIV*(2*WIDTH+3)+1 cycles after start.
// Backpressure: start is only sampled in IDLE (including the done cycle); requests while busy are dropped.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH    = SPI_WIDTH,
  parameter int HALF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             load
);

  localparam int BW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             phase_hi_q, phase_hi_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  spi_clk_div #(
    .HALF_DIV(HALF_DIV)
  ) u_clk_div (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE),
    .tick(tick)
  );

  // The phase flag doubles as SCLK and the shifter MSB doubles as MOSI, so both pins come straight from flops.
  assign sclk    = phase_hi_q;
  assign mosi    = tx_sr_q[WIDTH-1];
  assign load    = load_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    phase_hi_d = phase_hi_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    load_d     = load_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          tx_sr_d = tx_data;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        if (tick) begin
          state_d = SETUP;
          load_d  = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d    = SHIFT;
          phase_hi_d = 1'b1;
          bit_cnt_d  = BW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (tick && phase_hi_q) begin
          // Sample at the end of the high phase, then present the next bit on the falling edge.
          rx_sr_d    = {rx_sr_q[WIDTH-2:0], miso};
          tx_sr_d    = {tx_sr_q[WIDTH-2:0], 1'b0};
          phase_hi_d = 1'b0;
        end else if (tick) begin
          if (bit_cnt_q == '0) begin
            state_d = LATCH;
            load_d  = 1'b1;
          end else begin
            bit_cnt_d  = bit_cnt_q - BW'(1);
            phase_hi_d = 1'b1;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_d   = IDLE;
          load_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      phase_hi_q <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_hi_q <= phase_hi_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench: two masters (HALF_DIV=2 and 1) each talking to a behavioural mode-0 slave.
// Expected words are queued at stimulus time and popped by the negedge monitor on done/commit.
module tb_spi_master;

  localparam int W = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start0, start1;
  logic [W-1:0] tx0, tx1, rx0, rx1;
  logic         busy0, busy1, done0, done1, sclk0, sclk1;
  logic         mosi0, mosi1, miso0, miso1, load0, load1;

  spi_master #(.WIDTH(W), .HALF_DIV(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .tx_data(tx0), .busy(busy0), .done(done0),
    .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .miso(miso0), .load(load0)
  );

  spi_master #(.WIDTH(W), .HALF_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .busy(busy1), .done(done1),
    .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .load(load1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] sl_din[2], sl_sh[2], sl_rx[2], sl_dout[2];
  int           sl_cnt[2];
  logic         ps[2], pl[2];
  int           rises[2], loads[2], busy_low[2], done_cnt[2], t_start[2];
  bit           in_frame[2];
  int           lat[2] = '{59, 30};

  logic [W-1:0] exp_rx0[$], exp_rx1[$], exp_do0[$], exp_do1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input int i);
    checks++;
    failures++;
    $display("FAIL %s%0d: event with no queued expectation", nm, i);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic sc, ld, mo, dn, bz, st;
      logic [W-1:0] rd;
      sc = (i == 0) ? sclk0 : sclk1;
      ld = (i == 0) ? load0 : load1;
      mo = (i == 0) ? mosi0 : mosi1;
      dn = (i == 0) ? done0 : done1;
      bz = (i == 0) ? busy0 : busy1;
      st = (i == 0) ? start0 : start1;
      rd = (i == 0) ? rx0 : rx1;

      if (ld && !pl[i]) begin
        loads[i]++;
        if (sl_cnt[i] == W) begin
          sl_dout[i] = sl_rx[i];
          if (i == 0) begin
            if (exp_do0.size() > 0) chk("slave0 dout", 32'(sl_dout[0]), 32'(exp_do0.pop_front()));
            else unexpected("slave dout commit", 0);
          end else begin
            if (exp_do1.size() > 0) chk("slave1 dout", 32'(sl_dout[1]), 32'(exp_do1.pop_front()));
            else unexpected("slave dout commit", 1);
          end
        end else begin
          sl_sh[i] = sl_din[i];
        end
        sl_cnt[i] = 0;
      end
      if (sc && !ps[i]) begin
        sl_rx[i] = {sl_rx[i][W-2:0], mo};
        sl_cnt[i]++;
        rises[i]++;
      end
      if (!sc && ps[i]) sl_sh[i] = {sl_sh[i][W-2:0], 1'b0};
      ps[i] = sc;
      pl[i] = ld;

      if (in_frame[i] && cyc > t_start[i] && !bz) busy_low[i]++;
      if (dn) begin
        done_cnt[i]++;
        if (in_frame[i]) begin
          chk($sformatf("latency%0d", i), 32'(cyc - t_start[i]), 32'(lat[i]));
          chk($sformatf("sclk rises%0d", i), 32'(rises[i]), 32'(W));
          chk($sformatf("load pulses%0d", i), 32'(loads[i]), 32'd2);
          chk($sformatf("busy low cycles%0d", i), 32'(busy_low[i]), 32'd1);
        end
        if (i == 0) begin
          if (exp_rx0.size() > 0) chk("rx_data0", 32'(rd), 32'(exp_rx0.pop_front()));
          else unexpected("done", 0);
        end else begin
          if (exp_rx1.size() > 0) chk("rx_data1", 32'(rd), 32'(exp_rx1.pop_front()));
          else unexpected("done", 1);
        end
        in_frame[i] = 1'b0;
        if (st) begin
          t_start[i]  = cyc;
          rises[i]    = 0;
          loads[i]    = 0;
          busy_low[i] = 0;
          in_frame[i] = 1'b1;
        end
      end
    end
    miso0 = sl_sh[0][W-1];
    miso1 = sl_sh[1][W-1];
  end

  task automatic start_frame(input int i, input logic [W-1:0] tx);
    @(posedge clk); #1;
    if (i == 0) begin tx0 = tx; start0 = 1'b1; end
    else begin tx1 = tx; start1 = 1'b1; end
    t_start[i]  = cyc;
    rises[i]    = 0;
    loads[i]    = 0;
    busy_low[i] = 0;
    in_frame[i] = 1'b1;
    @(posedge clk); #1;
    if (i == 0) start0 = 1'b0;
    else start1 = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n0 = done_cnt[i];
    int k = 0;
    while (done_cnt[i] == n0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_cnt[i] == n0) begin
      checks++;
      failures++;
      $display("FAIL wait_done%0d: no done within %0d cycles", i, budget);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; tx0 = '0; tx1 = '0;
    miso0 = 1'b0; miso1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sl_din[i] = 13'h0F0F; sl_sh[i] = '0; sl_rx[i] = '0; sl_dout[i] = '0; sl_cnt[i] = 0;
      ps[i] = 1'b0; pl[i] = 1'b0; rises[i] = 0; loads[i] = 0; busy_low[i] = 0;
      done_cnt[i] = 0; t_start[i] = 0; in_frame[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset sclk", 32'(sclk0), 32'd0);
    chk("reset load", 32'(load0), 32'd0);
    chk("reset mosi", 32'(mosi0), 32'd0);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk("reset rx_data", 32'(rx0), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Loopback plus frame timing.
    exp_rx0.push_back(13'h0F0F); exp_do0.push_back(13'h1ABC);
    start_frame(0, 13'h1ABC);
    wait_done(0, 200);

    // Start during SHIFT must be dropped.
    n = done_cnt[0];
    exp_rx0.push_back(13'h0F0F); exp_do0.push_back(13'h1ABC);
    start_frame(0, 13'h1ABC);
    repeat (20) @(posedge clk);
    #1 tx0 = 13'h0000; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_done(0, 200);
    repeat (15) @(negedge clk);
    #1 chk("single done on busy start", 32'(done_cnt[0] - n), 32'd1);

    // Back-to-back frames with start held high.
    exp_rx0.push_back(13'h0F0F); exp_rx0.push_back(13'h0F0F);
    exp_do0.push_back(13'h1FFF); exp_do0.push_back(13'h0001);
    @(posedge clk); #1;
    tx0 = 13'h1FFF; start0 = 1'b1;
    t_start[0] = cyc; rises[0] = 0; loads[0] = 0; busy_low[0] = 0; in_frame[0] = 1'b1;
    @(posedge clk); #1 tx0 = 13'h0001;
    wait_done(0, 200);
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    chk("b2b load after done", 32'(load0), 32'd1);
    chk("b2b busy after done", 32'(busy0), 32'd1);
    wait_done(0, 200);

    // Reset after five SCLK rises aborts the frame.
    n = done_cnt[0];
    start_frame(0, 13'h1ABC);
    begin
      int k = 0;
      while (rises[0] < 5 && k < 200) begin @(negedge clk); #1; k++; end
      if (rises[0] < 5) begin
        checks++; failures++;
        $display("FAIL abort wait: only %0d rises within 200 cycles", rises[0]);
      end
    end
    @(posedge clk); #1 rst = 1'b1; in_frame[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort sclk", 32'(sclk0), 32'd0);
    chk("abort load", 32'(load0), 32'd0);
    chk("abort busy", 32'(busy0), 32'd0);
    chk("abort rx_data", 32'(rx0), 32'd0);
    repeat (10) @(negedge clk);
    #1 chk("abort no done", 32'(done_cnt[0] - n), 32'd0);
    sl_din[0] = 13'h0A5A;
    exp_rx0.push_back(13'h0A5A); exp_do0.push_back(13'h1ABC);
    start_frame(0, 13'h1ABC);
    wait_done(0, 200);

    // Same loopback with HALF_DIV=1.
    exp_rx1.push_back(13'h0F0F); exp_do1.push_back(13'h1ABC);
    start_frame(1, 13'h1ABC);
    wait_done(1, 100);

    repeat (10) @(negedge clk);
    chk("rx queue0 drained", 32'(exp_rx0.size()), 32'd0);
    chk("dout queue0 drained", 32'(exp_do0.size()), 32'd0);
    chk("rx queue1 drained", 32'(exp_rx1.size()), 32'd0);
    chk("dout queue1 drained", 32'(exp_do1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
